// File: rtl/cu_read_command_issue.sv
// Read-command issue stage: buffers CU read commands, tags each one and forwards
// it to the PSL command interface while credits and the next tag are available.
module cu_read_command_issue #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned SIZE_WIDTH   = 12,
  parameter int unsigned CMD_WIDTH    = 13,
  parameter int unsigned CREDIT_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled_in,
  input  logic                    cmd_in_valid,
  input  logic [ADDR_WIDTH-1:0]   cmd_in_address,
  input  logic [SIZE_WIDTH-1:0]   cmd_in_size,
  input  logic [CMD_WIDTH-1:0]    cmd_in_cmd,
  output logic                    cmd_almost_full,
  input  logic                    credit_load,
  input  logic [CREDIT_WIDTH-1:0] credit_room_in,
  output logic                    psl_cmd_valid,
  output logic [TAG_WIDTH-1:0]    psl_cmd_tag,
  output logic [ADDR_WIDTH-1:0]   psl_cmd_address,
  output logic [SIZE_WIDTH-1:0]   psl_cmd_size,
  output logic [CMD_WIDTH-1:0]    psl_cmd_code,
  input  logic                    rsp_valid,
  input  logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic [CREDIT_WIDTH-1:0] credits_out,
  output logic [TAG_WIDTH:0]      outstanding_count,
  output logic                    overflow_error,
  output logic                    tag_error
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned NTAGS = 1 << TAG_WIDTH;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] AFULL_C = (PTR_W+1)'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [SIZE_WIDTH-1:0] size;
    logic [CMD_WIDTH-1:0]  code;
  } cmd_t;

  logic                    in_valid_q;
  cmd_t                    in_cmd_q;
  cmd_t                    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q, count_d;
  logic [NTAGS-1:0]        outstanding_q, outstanding_d;
  logic [TAG_WIDTH-1:0]    next_tag_q;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [TAG_WIDTH:0]      out_cnt_q, out_cnt_d;
  logic                    valid_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  cmd_t                    out_q;
  logic                    afull_q, ovf_q, tag_err_q;
  logic                    rsp_hit, rsp_bad, tag_free, issue, push_ok;
  cmd_t                    head;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    rsp_hit  = rsp_valid & outstanding_q[rsp_tag];
    rsp_bad  = rsp_valid & ~outstanding_q[rsp_tag];
    // A response retiring next_tag frees it for an issue in the same cycle.
    tag_free = ~outstanding_q[next_tag_q] | (rsp_hit & (rsp_tag == next_tag_q));
    issue    = enabled_in & (count_q != '0) & (credits_q != '0) & tag_free;
    push_ok  = in_valid_q & ((count_q < DEPTH_C) | issue);
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !issue)      count_d = count_q + 1'b1;
    else if (!push_ok && issue) count_d = count_q - 1'b1;

    outstanding_d = outstanding_q;
    if (rsp_hit) outstanding_d[rsp_tag]    = 1'b0;
    if (issue)   outstanding_d[next_tag_q] = 1'b1;

    out_cnt_d = out_cnt_q;
    if (rsp_hit && !issue)      out_cnt_d = out_cnt_q - 1'b1;
    else if (issue && !rsp_hit) out_cnt_d = out_cnt_q + 1'b1;

    // A load overrides any return or consumption in the same cycle.
    credits_d = credits_q;
    if (credit_load) begin
      credits_d = credit_room_in;
    end else if (rsp_hit && !issue) begin
      if (credits_q != '1) credits_d = credits_q + 1'b1;
    end else if (issue && !rsp_hit) begin
      credits_d = credits_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rstn) begin
      in_valid_q    <= 1'b0;
      in_cmd_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      next_tag_q    <= '0;
      credits_q     <= '0;
      out_cnt_q     <= '0;
      valid_q       <= 1'b0;
      tag_q         <= '0;
      out_q         <= '0;
      afull_q       <= 1'b0;
      ovf_q         <= 1'b0;
      tag_err_q     <= 1'b0;
    end else begin
      in_valid_q    <= cmd_in_valid;
      in_cmd_q      <= {cmd_in_address, cmd_in_size, cmd_in_cmd};
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      credits_q     <= credits_d;
      out_cnt_q     <= out_cnt_d;
      afull_q       <= (count_d >= AFULL_C);
      valid_q       <= issue;
      if (issue) begin
        tag_q      <= next_tag_q;
        out_q      <= head;
        next_tag_q <= next_tag_q + 1'b1;
      end
      ovf_q     <= ovf_q | (in_valid_q & ~push_ok);
      tag_err_q <= tag_err_q | rsp_bad;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_cmd_q;
  end

  assign cmd_almost_full   = afull_q;
  assign psl_cmd_valid     = valid_q;
  assign psl_cmd_tag       = tag_q;
  assign psl_cmd_address   = out_q.addr;
  assign psl_cmd_size      = out_q.size;
  assign psl_cmd_code      = out_q.code;
  assign credits_out       = credits_q;
  assign outstanding_count = out_cnt_q;
  assign overflow_error    = ovf_q;
  assign tag_error         = tag_err_q;
endmodule

// File: tb/tb_cu_read_command_issue.sv
// Bench for cu_read_command_issue: directed scenarios plus randomized traffic,
// checked by a scoreboard monitor against a transaction-level reference model.
module tb_cu_read_command_issue;
  localparam int unsigned FD  = 16;
  localparam int unsigned TW  = 4;
  localparam int unsigned AW  = 64;
  localparam int unsigned SW  = 12;
  localparam int unsigned CW  = 13;
  localparam int unsigned CRW = 8;
  localparam int unsigned NT  = 1 << TW;

  logic           clock = 1'b0;
  logic           rstn = 1'b1;
  logic           enabled_in = 1'b1;
  logic           cmd_in_valid = 1'b0;
  logic [AW-1:0]  cmd_in_address = '0;
  logic [SW-1:0]  cmd_in_size = '0;
  logic [CW-1:0]  cmd_in_cmd = '0;
  logic           cmd_almost_full;
  logic           credit_load = 1'b0;
  logic [CRW-1:0] credit_room_in = '0;
  logic           psl_cmd_valid;
  logic [TW-1:0]  psl_cmd_tag;
  logic [AW-1:0]  psl_cmd_address;
  logic [SW-1:0]  psl_cmd_size;
  logic [CW-1:0]  psl_cmd_code;
  logic           rsp_valid = 1'b0;
  logic [TW-1:0]  rsp_tag = '0;
  logic [CRW-1:0] credits_out;
  logic [TW:0]    outstanding_count;
  logic           overflow_error;
  logic           tag_error;

  always #5 clock = ~clock;

  cu_read_command_issue #(
    .FIFO_DEPTH(FD), .TAG_WIDTH(TW), .ADDR_WIDTH(AW),
    .SIZE_WIDTH(SW), .CMD_WIDTH(CW), .CREDIT_WIDTH(CRW)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .cmd_in_valid(cmd_in_valid), .cmd_in_address(cmd_in_address),
    .cmd_in_size(cmd_in_size), .cmd_in_cmd(cmd_in_cmd),
    .cmd_almost_full(cmd_almost_full), .credit_load(credit_load),
    .credit_room_in(credit_room_in), .psl_cmd_valid(psl_cmd_valid),
    .psl_cmd_tag(psl_cmd_tag), .psl_cmd_address(psl_cmd_address),
    .psl_cmd_size(psl_cmd_size), .psl_cmd_code(psl_cmd_code),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .credits_out(credits_out),
    .outstanding_count(outstanding_count), .overflow_error(overflow_error),
    .tag_error(tag_error)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [CW-1:0] code;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned pool[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned n_issued = 0;

  // Reference model: tags are handed out sequentially, commands leave in push order.
  bit          m_out[NT];
  int          m_credits, m_outcnt;
  int unsigned m_next;
  bit          m_tagerr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic          s_rst, s_en, s_rv, s_ld;
  logic [TW-1:0] s_rt;
  logic [CRW-1:0] s_room;
  bit            good, issued, legal;
  exp_t          e;

  always begin
    @(posedge clock);
    s_rst = rstn; s_en = enabled_in; s_rv = rsp_valid; s_rt = rsp_tag;
    s_ld = credit_load; s_room = credit_room_in;
    #1;
    if (s_rst) begin
      foreach (m_out[i]) m_out[i] = 1'b0;
      m_credits = 0; m_outcnt = 0; m_next = 0; m_tagerr = 1'b0;
      pool.delete();
      exp_q.delete();
    end else begin
      good = s_rv && m_out[s_rt];
      if (s_rv && !m_out[s_rt]) m_tagerr = 1'b1;
      issued = psl_cmd_valid;
      if (issued) begin
        n_issued++;
        legal = s_en && (m_credits > 0) && (!m_out[m_next] || (good && s_rt == m_next));
        chk("issue_legal", legal ? 64'd1 : 64'd0, 64'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", psl_cmd_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("issue_tag", psl_cmd_tag, m_next);
          chk("issue_addr", psl_cmd_address, e.addr);
          chk("issue_size", psl_cmd_size, e.size);
          chk("issue_code", psl_cmd_code, e.code);
        end
      end
      if (good) begin m_out[s_rt] = 1'b0; m_outcnt--; end
      if (issued) begin
        m_out[m_next] = 1'b1; m_outcnt++;
        pool.push_back(m_next);
        m_next = (m_next + 1) % NT;
      end
      if (s_ld) m_credits = s_room;
      else if (good && !issued) begin if (m_credits < 255) m_credits++; end
      else if (issued && !good) m_credits--;
      chk("credits", credits_out, m_credits);
      chk("outstanding", outstanding_count, m_outcnt);
      chk("tag_error", tag_error, m_tagerr);
    end
  end

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
    cmd_in_valid = 1'b0; rsp_valid = 1'b0; credit_load = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [SW-1:0] s,
                      input logic [CW-1:0] c, input bit accept);
    cmd_in_valid = 1'b1; cmd_in_address = a; cmd_in_size = s; cmd_in_cmd = c;
    if (accept) exp_q.push_back('{a, s, c});
  endtask

  task automatic load(input int unsigned v);
    credit_load = 1'b1; credit_room_in = CRW'(v);
  endtask

  task automatic rsp_all();
    while (pool.size() > 0) begin
      rsp_valid = 1'b1; rsp_tag = TW'(pool.pop_front());
      cycle();
    end
    cycle();
  endtask

  task automatic do_reset();
    rstn = 1'b1; cycle(); rstn = 1'b0;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_valid"}, psl_cmd_valid, 0);
    chk({p, "_tag"}, psl_cmd_tag, 0);
    chk({p, "_addr"}, psl_cmd_address, 0);
    chk({p, "_size"}, psl_cmd_size, 0);
    chk({p, "_code"}, psl_cmd_code, 0);
    chk({p, "_credits"}, credits_out, 0);
    chk({p, "_outcnt"}, outstanding_count, 0);
    chk({p, "_afull"}, cmd_almost_full, 0);
    chk({p, "_ovf"}, overflow_error, 0);
    chk({p, "_tagerr"}, tag_error, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned old_tags[$];
    int unsigned guard, n0, k;
    @(negedge clock);
    cycle(); cycle();
    rstn = 1'b0;
    check_reset("rst");

    // Basic flow and first-issue latency.
    load(4); cycle();
    push(64'h1000, 12'h080, 13'h0A00, 1); cycle(); chk("basic_lat1", psl_cmd_valid, 0);
    push(64'h1080, 12'h080, 13'h0A00, 1); cycle(); chk("basic_lat2", psl_cmd_valid, 0);
    push(64'h1100, 12'h080, 13'h0A00, 1); cycle(); chk("basic_issue0", psl_cmd_valid, 1);
    cycle(); chk("basic_issue1", psl_cmd_valid, 1);
    cycle(); chk("basic_issue2", psl_cmd_valid, 1);
    cycle(); chk("basic_pulse_end", psl_cmd_valid, 0);
    chk("basic_credits", credits_out, 1);
    chk("basic_outcnt", outstanding_count, 3);
    rsp_all();
    chk("basic_credits_back", credits_out, 4);

    // Credit stall and resume on response.
    load(2); cycle();
    for (int unsigned i = 0; i < 4; i++) begin
      push(64'h2000 + 64'(i * 128), 12'h080, 13'h0A01, 1); cycle();
    end
    repeat (6) cycle();
    chk("stall_credits", credits_out, 0);
    chk("stall_outcnt", outstanding_count, 2);
    rsp_valid = 1'b1; rsp_tag = TW'(pool[1]); pool.delete(1); cycle();
    chk("stall_hold", psl_cmd_valid, 0);
    chk("stall_credit_ret", credits_out, 1);
    cycle(); chk("stall_resume", psl_cmd_valid, 1);
    rsp_valid = 1'b1; rsp_tag = TW'(pool[0]); pool.delete(0); cycle();
    cycle(); chk("stall_resume2", psl_cmd_valid, 1);
    chk("stall_credits_zero", credits_out, 0);
    rsp_all();
    chk("stall_credits_back", credits_out, 2);

    // Issue and valid response on the same edge.
    push(64'h3000, 12'h040, 13'h0A02, 1); cycle();
    repeat (4) cycle();
    chk("simul_pre_credits", credits_out, 1);
    push(64'h3040, 12'h040, 13'h0A02, 1); cycle();
    cycle();
    rsp_valid = 1'b1; rsp_tag = TW'(pool.pop_front()); cycle();
    chk("simul_issue", psl_cmd_valid, 1);
    chk("simul_credits", credits_out, 1);
    rsp_all();

    // Response for a tag that is not outstanding.
    rsp_valid = 1'b1; rsp_tag = 4'd5; cycle();
    chk("bad_rsp_tagerr", tag_error, 1);
    chk("bad_rsp_credits", credits_out, 2);

    // Reset in the middle of traffic.
    do_reset();
    load(3); cycle();
    for (int unsigned i = 0; i < 5; i++) begin
      push(64'h4000 + 64'(i * 64), 12'h020, 13'h0A03, 1); cycle();
    end
    repeat (6) cycle();
    chk("midrst_pre_outcnt", outstanding_count, 3);
    old_tags = pool;
    do_reset();
    check_reset("midrst");
    repeat (6) begin cycle(); chk("midrst_quiet", psl_cmd_valid, 0); end
    rsp_valid = 1'b1; rsp_tag = TW'(old_tags[0]); cycle();
    chk("stale_rsp_tagerr", tag_error, 1);
    chk("stale_rsp_credits", credits_out, 0);

    // Randomized traffic.
    do_reset();
    load(8); cycle();
    for (int unsigned c = 0; c < 1500; c++) begin
      enabled_in = ($urandom_range(0, 9) != 0);
      if (!cmd_almost_full && $urandom_range(0, 2) != 0)
        push({$urandom, $urandom}, SW'($urandom), CW'($urandom), 1);
      if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, pool.size() - 1);
        rsp_valid = 1'b1; rsp_tag = TW'(pool[k]); pool.delete(k);
      end
      if ($urandom_range(0, 39) == 0)
        load(($urandom_range(0, 7) == 0) ? 255 : $urandom_range(1, 12));
      cycle();
    end
    enabled_in = 1'b1;
    guard = 0;
    while ((exp_q.size() > 0 || pool.size() > 0) && guard < 4000) begin
      if (pool.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, pool.size() - 1);
        rsp_valid = 1'b1; rsp_tag = TW'(pool[k]); pool.delete(k);
      end
      cycle();
      guard++;
    end
    cycle();
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_outcnt", outstanding_count, 0);

    // Overflow with issue disabled, then release.
    do_reset();
    enabled_in = 1'b0;
    load(20); cycle();
    for (int unsigned i = 0; i < 17; i++) begin
      push(64'h8000 + 64'(i * 128), 12'h080, CW'(i), i < 16); cycle();
      chk("ovf_afull", cmd_almost_full, i >= 14);
      chk("ovf_flag_low", overflow_error, 0);
    end
    cycle();
    chk("ovf_flag_set", overflow_error, 1);
    chk("ovf_afull_full", cmd_almost_full, 1);
    n0 = n_issued;
    enabled_in = 1'b1;
    repeat (30) cycle();
    chk("ovf_issued", n_issued - n0, 16);
    chk("ovf_credits", credits_out, 4);
    chk("ovf_afull_clear", cmd_almost_full, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
